// File: rtl/rom_read_arbiter.sv
// Two-requester burst reader for a synchronous ROM with one-cycle read latency.
// Define ROM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module rom_read_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_i,
    input  logic [ADDR_W-1:0] base0_i,
    input  logic [ADDR_W-1:0] base1_i,
    input  logic [7:0]        len0_i,
    input  logic [7:0]        len1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        done_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);

    state_t            state_q;
    logic              owner_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        rem_q;
    logic              issue_q;
    logic [1:0]        gnt_q;
    logic [1:0]        rvalid_q;
    logic [1:0]        done_q;
    logic              busy_q;

    logic              win;
    logic [1:0]        win_oh;
    logic [1:0]        owner_oh;
    logic [ADDR_W-1:0] base_sel;
    logic [7:0]        len_sel;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] cnt_inc;
    logic [8:0]        rem_load;

`ifdef ROM_ARB_RR_EN
    logic ptr_q;

    // Only a tie consults the pointer; a lone request always wins.
    always_comb win = (&req_i) ? ptr_q : ~req_i[0];
`else
    always_comb win = ~req_i[0];
`endif

    always_comb begin
        base_sel   = win ? base1_i : base0_i;
        len_sel    = win ? len1_i : len0_i;
        start_addr = ADDR_W'({1'b0, base_sel} % DEPTH_W);
        rem_load   = (len_sel == 8'd0) ? 9'd256 : {1'b0, len_sel};
        cnt_inc    = (cnt_q == LAST_ADDR) ? '0 : cnt_q + ADDR_W'(1);
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
        assign win_oh[gi]   = (win == 1'(gi));
        assign owner_oh[gi] = (owner_q == 1'(gi));
    end

    // rem_q counts addresses still to issue; data follows each issue by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            rem_q    <= '0;
            issue_q  <= 1'b0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            done_q   <= 2'b00;
            busy_q   <= 1'b0;
`ifdef ROM_ARB_RR_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            issue_q  <= 1'b0;
            rvalid_q <= issue_q ? owner_oh : 2'b00;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        owner_q <= win;
                        gnt_q   <= win_oh;
                        cnt_q   <= start_addr;
                        rem_q   <= rem_load;
                        busy_q  <= 1'b1;
                        state_q <= BURST;
`ifdef ROM_ARB_RR_EN
                        ptr_q   <= ~win;
`endif
                    end
                end
                BURST: begin
                    if (rem_q != 9'd0) begin
                        addr_q  <= cnt_q;
                        cnt_q   <= cnt_inc;
                        rem_q   <= rem_q - 9'd1;
                        issue_q <= 1'b1;
                    end else begin
                        done_q  <= owner_oh;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o      = gnt_q;
    assign rvalid_o   = rvalid_q;
    assign done_o     = done_q;
    assign busy_o     = busy_q;
    assign rom_addr_o = addr_q;
    assign rdata_o    = (|rvalid_q) ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Randomized and directed bench for rom_read_arbiter with a burst-schedule reference model.
// Define ROM_ARB_RR_EN here too when the design is built with round-robin arbitration.
module tb_rom_read_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;
`ifdef ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req;
    logic [ADDR_W-1:0] base0, base1;
    logic [7:0]        len0, len1;
    logic [1:0]        gnt_o, rvalid_o, done_o;
    logic [DATA_W-1:0] rdata_o;
    logic              busy_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] rom_mem [DEPTH];

    rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .base0_i    (base0),
        .base1_i    (base1),
        .len0_i     (len0),
        .len1_i     (len1),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_q)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears one cycle later.
    always @(posedge clk) rom_q <= rom_mem[int'(rom_addr_o) % DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a granted burst starting at cycle g with length L shows
    // addresses in g+1..g+L, data in g+2..g+L+1, done at g+L+1, next arbitration at g+L+2.
    int          g = -1000;
    int          blen = 0;
    int          nxt_idle = 0;
    int          last_win = 1;
    int          mbase = 0;
    int          mown = 0;
    logic [15:0] m_addr = '0;
    logic [1:0]  e_gnt, e_rv, e_done, m_oh;
    logic        e_busy;
    logic [7:0]  e_data;
    int          w, ln;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            g = -1000; blen = 0; nxt_idle = cyc; last_win = 1; m_addr = '0;
        end
        m_oh   = (mown == 1) ? 2'b10 : 2'b01;
        e_gnt  = (cyc == g) ? m_oh : 2'b00;
        e_busy = (cyc >= g) && (cyc <= g + blen + 1);
        if (cyc >= g + 1 && cyc <= g + blen) m_addr = 16'((mbase + cyc - g - 1) % DEPTH);
        e_rv   = 2'b00;
        e_data = '0;
        if (cyc >= g + 2 && cyc <= g + blen + 1) begin
            e_rv   = m_oh;
            e_data = rom_mem[(mbase + cyc - g - 2) % DEPTH];
        end
        e_done = (cyc == g + blen + 1) ? m_oh : 2'b00;
        chk("gnt", 32'(gnt_o), 32'(e_gnt));
        chk("busy", 32'(busy_o), 32'(e_busy));
        chk("rom_addr", 32'(rom_addr_o), 32'(m_addr));
        chk("rvalid", 32'(rvalid_o), 32'(e_rv));
        chk("done", 32'(done_o), 32'(e_done));
        if (e_rv != 2'b00) chk("rdata", 32'(rdata_o), 32'(e_data));
        if (rst_n && cyc >= nxt_idle && req != 2'b00) begin
            if (req == 2'b11) w = RR ? ((last_win == 0) ? 1 : 0) : 0;
            else              w = req[1] ? 1 : 0;
            mown     = w;
            mbase    = int'(w == 1 ? base1 : base0) % DEPTH;
            ln       = int'(w == 1 ? len1 : len0);
            blen     = (ln == 0) ? 256 : ln;
            g        = cyc + 1;
            nxt_idle = g + blen + 2;
            last_win = w;
        end
    end

    task automatic wait_gnt(input string name, input logic [1:0] want);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            if (gnt_o != 2'b00) seen = 1'b1;
        end
        chk({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) chk(name, 32'(gnt_o), 32'(want));
    endtask

    task automatic wait_idle(input string name);
        int quiet;
        quiet = 0;
        for (int k = 0; k < 2000 && quiet < 3; k++) begin
            @(negedge clk);
            quiet = busy_o ? 0 : quiet + 1;
        end
        chk({name, "_idle"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic drive(input logic [1:0] r);
        @(posedge clk); #1;
        req = r;
    endtask

    logic [15:0] wrap_exp [4] = '{16'h03FE, 16'h03FF, 16'h0000, 16'h0001};
    logic [1:0]  cont_exp [3];
    int          rv, dn, dn_ok, dcyc, gcyc;
    logic [1:0]  nreq;

    initial begin
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = 8'($urandom);
        if (RR) cont_exp = '{2'b01, 2'b10, 2'b01};
        else    cont_exp = '{2'b01, 2'b01, 2'b01};
        rst_n = 1'b0; req = 2'b00; base0 = '0; base1 = '0; len0 = 8'd1; len1 = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(gnt_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_addr", 32'(rom_addr_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single burst from requester 0.
        @(posedge clk); #1;
        base0 = 16'h0010; len0 = 8'd4; req = 2'b01;
        wait_gnt("t1_gnt", 2'b01);
        drive(2'b00);
        rv = 0; dn = 0; dn_ok = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k <= 4) chk($sformatf("t1_addr%0d", k), 32'(rom_addr_o), 32'(32'h10 + k - 1));
            if (rvalid_o[0]) rv++;
            if (done_o[0]) begin dn++; if (k == 5 && rvalid_o[0]) dn_ok = 1; end
        end
        chk("t1_rvalid_count", 32'(rv), 32'd4);
        chk("t1_done_count", 32'(dn), 32'd1);
        chk("t1_done_with_last", 32'(dn_ok), 32'd1);
        wait_idle("t1");

        // Address wrap for requester 1.
        @(posedge clk); #1;
        base1 = 16'h03FE; len1 = 8'd4; req = 2'b10;
        wait_gnt("t2_gnt", 2'b10);
        drive(2'b00);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("t2_addr%0d", k), 32'(rom_addr_o), 32'(wrap_exp[k-1]));
        end
        wait_idle("t2");

        // Contention held across three bursts.
        @(posedge clk); #1;
        base0 = 16'h0040; base1 = 16'h0080; len0 = 8'd2; len1 = 8'd2; req = 2'b11;
        for (int i = 0; i < 3; i++) wait_gnt($sformatf("t3_gnt%0d", i), cont_exp[i]);
        drive(2'b00);
        wait_idle("t3");

        // len 0 means 256 words.
        @(posedge clk); #1;
        base0 = 16'h03F0; len0 = 8'd0; req = 2'b01;
        wait_gnt("t4_gnt", 2'b01);
        drive(2'b00);
        rv = 0; dn = 0;
        for (int k = 1; k <= 262; k++) begin
            @(negedge clk);
            if (rvalid_o[0]) rv++;
            if (done_o[0]) dn++;
        end
        chk("t4_rvalid_count", 32'(rv), 32'd256);
        chk("t4_done_count", 32'(dn), 32'd1);
        wait_idle("t4");

        // Reset mid-burst, then a fresh request from requester 1.
        @(posedge clk); #1;
        base0 = 16'h0100; len0 = 8'd8; req = 2'b01;
        wait_gnt("t5_gnt", 2'b01);
        drive(2'b00);
        for (int k = 1; k <= 3; k++) @(negedge clk);
        chk("t5_addr3", 32'(rom_addr_o), 32'h102);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(gnt_o), 32'd0);
        chk("t5_rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("t5_rst_done", 32'(done_o), 32'd0);
        chk("t5_rst_busy", 32'(busy_o), 32'd0);
        chk("t5_rst_addr", 32'(rom_addr_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; base1 = 16'h0020; len1 = 8'd3; req = 2'b10;
        wait_gnt("t5_gnt_after_reset", 2'b10);
        drive(2'b00);
        wait_idle("t5");

        // Request from requester 1 raised mid-burst stays pending.
        @(posedge clk); #1;
        base0 = 16'h0200; len0 = 8'd6; req = 2'b01;
        wait_gnt("t6_gnt0", 2'b01);
        drive(2'b00);
        @(posedge clk); #1;
        base1 = 16'h0300; len1 = 8'd2; req = 2'b10;
        dcyc = -100; gcyc = -1;
        for (int k = 0; k < 40 && gcyc < 0; k++) begin
            @(negedge clk);
            if (done_o[0]) dcyc = k;
            if (gnt_o[1]) gcyc = k;
        end
        chk("t6_gnt1_seen", 32'(gcyc >= 0), 32'd1);
        chk("t6_gnt_gap", 32'(gcyc - dcyc), 32'd2);
        drive(2'b00);
        wait_idle("t6");

        // Random traffic; base/len only change when a request rises.
        for (int it = 0; it < 40; it++) begin
            @(posedge clk); #1;
            nreq = 2'($urandom_range(0, 3));
            if (nreq[0] && !req[0]) begin
                base0 = 16'($urandom_range(0, DEPTH - 1)); len0 = 8'($urandom_range(0, 15));
            end
            if (nreq[1] && !req[1]) begin
                base1 = 16'($urandom_range(0, DEPTH - 1)); len1 = 8'($urandom_range(0, 15));
            end
            req = nreq;
            repeat ($urandom_range(0, 24)) @(posedge clk);
        end
        drive(2'b00);
        wait_idle("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
